reg_file_wb: RTL

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb_pkg.sv | 31 +++
 rtl/reg_scoreboard.sv | 68 ++++++
 rtl/reg_file_wb.sv | 83 ++++++++
 3 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared CPU constants and types for the register file / scoreboard slice.
//   NUM_REGS, DATA_W, ADDR_W : register file geometry
//   CNT_W                    : width of the busy-register count
//   popcount()               : number of set bits in a busy vector
package reg_file_wb_pkg;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned CNT_W    = 5;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   // Write-back request as seen by the register file.
   typedef struct packed {
      logic      en;
      reg_idx_t  idx;
      reg_data_t data;
   } wb_req_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: tracks registers with an outstanding producer,
// flags read-after-write and write-after-write hazards, counts busy entries.
//   clk, reset              : clock, synchronous active-high reset
//   wr_en_i, wr_idx_i       : write-back (clears busy)
//   rd1_idx_i, rd2_idx_i    : operand indices checked for RAW hazards
//   iss_valid_i, iss_dest_i : issuing instruction (sets busy, WAW check)
//   stall_c_o               : combinational hazard flag for this cycle
//   pending_o               : registered popcount of the registered busy vector
module reg_scoreboard
   import reg_file_wb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  reg_idx_t         wr_idx_i,
   input  reg_idx_t         rd1_idx_i,
   input  reg_idx_t         rd2_idx_i,
   input  logic             iss_valid_i,
   input  reg_idx_t         iss_dest_i,
   output logic             stall_c_o,
   output logic [CNT_W-1:0] pending_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]    pending_q, pending_d;
   logic                wr_hit, haz1, haz2, waw, issue_set;

   // Hazard detection and next busy state.
   always_comb begin
      wr_hit    = wr_en_i && (wr_idx_i != '0);
      // A same-cycle write to the register resolves the hazard via bypass.
      haz1      = (rd1_idx_i != '0) && busy_q[rd1_idx_i] &&
                  !(wr_hit && (wr_idx_i == rd1_idx_i));
      haz2      = (rd2_idx_i != '0) && busy_q[rd2_idx_i] &&
                  !(wr_hit && (wr_idx_i == rd2_idx_i));
      waw       = iss_valid_i && (iss_dest_i != '0) && busy_q[iss_dest_i] &&
                  !(wr_hit && (wr_idx_i == iss_dest_i));
      stall_c_o = haz1 || haz2 || waw;
      issue_set = iss_valid_i && (iss_dest_i != '0) && !stall_c_o;

      busy_d = busy_q;
      if (wr_hit) begin
         busy_d[wr_idx_i] = 1'b0;
      end
      // Applied after the clear so a new producer wins over a retiring one.
      if (issue_set) begin
         busy_d[iss_dest_i] = 1'b1;
      end
      busy_d[0] = 1'b0;

      // Count lags the busy vector by one cycle.
      pending_d = popcount(busy_q);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q    <= '0;
         pending_q <= '0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/reg_file_wb.sv
// 16 x 16-bit register file with write-back bypass and a busy scoreboard.
//   clk, reset                       : clock, synchronous active-high reset
//   regWrite, writeReg, regWriteData : write-back port
//   readReg1/2 -> reg1Data/reg2Data  : combinational read ports (R0 reads 0)
//   issueValid, issueDest            : issuing instruction with deferred result
//   stall                            : operand or destination hazard this cycle
//   pendingCount                     : registered count of busy registers
module reg_file_wb
   import reg_file_wb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] regWriteData,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic              issueValid,
   input  logic [ADDR_W-1:0] issueDest,
   output logic [DATA_W-1:0] reg1Data,
   output logic [DATA_W-1:0] reg2Data,
   output logic              stall,
   output logic [CNT_W-1:0]  pendingCount
);

   reg_data_t regs_q [NUM_REGS];
   reg_data_t regs_d [NUM_REGS];
   wb_req_t   wb;
   logic      wr_hit;

   // Write-back request; writes to R0 are dropped.
   always_comb begin
      wb.en   = regWrite;
      wb.idx  = writeReg;
      wb.data = regWriteData;
      wr_hit  = wb.en && (wb.idx != '0);
   end

   // Next register contents.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[wb.idx] = wb.data;
      end
   end

   // Register storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Zero-latency reads with same-cycle write-back bypass.
   always_comb begin
      reg1Data = '0;
      reg2Data = '0;
      if (readReg1 != '0) begin
         reg1Data = (wr_hit && (wb.idx == readReg1)) ? wb.data : regs_q[readReg1];
      end
      if (readReg2 != '0) begin
         reg2Data = (wr_hit && (wb.idx == readReg2)) ? wb.data : regs_q[readReg2];
      end
   end

   reg_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (regWrite),
      .wr_idx_i    (writeReg),
      .rd1_idx_i   (readReg1),
      .rd2_idx_i   (readReg2),
      .iss_valid_i (issueValid),
      .iss_dest_i  (issueDest),
      .stall_c_o   (stall),
      .pending_o   (pendingCount)
   );

endmodule
